// File: rtl/ghost_mode_ctrl.sv
// Per-ghost behaviour sequencer: scatter/chase schedule, frightened overlay
// after a power pellet, and eaten-ghost tracking until it reaches home.
module ghost_mode_ctrl #(
  parameter int unsigned SCATTER_LONG  = 420,
  parameter int unsigned SCATTER_SHORT = 300,
  parameter int unsigned CHASE_LEN     = 1200,
  parameter int unsigned FRIGHT_TICKS  = 360,
  parameter int unsigned FLASH_TICKS   = 120
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       restart,
  input  logic       pellet_eaten,
  input  logic       ghost_eaten,
  input  logic       ghost_home,
  output logic [1:0] mode,
  output logic       reverse,
  output logic       flash,
  output logic [2:0] phase
);

  typedef enum logic [1:0] {
    CHASE   = 2'd0,
    SCATTER = 2'd1,
    AFFRAID = 2'd2,
    EATEN   = 2'd3
  } ghost_modes_t;

  localparam int unsigned SCHED_MAX = (SCATTER_LONG > CHASE_LEN) ? SCATTER_LONG : CHASE_LEN;
  localparam int unsigned SCHED_W   = $clog2(SCHED_MAX + 1);
  localparam int unsigned FRIGHT_W  = $clog2(FRIGHT_TICKS + 1);

  localparam logic [SCHED_W-1:0]  LEN_SL = SCHED_W'(SCATTER_LONG);
  localparam logic [SCHED_W-1:0]  LEN_SS = SCHED_W'(SCATTER_SHORT);
  localparam logic [SCHED_W-1:0]  LEN_CH = SCHED_W'(CHASE_LEN);
  localparam logic [FRIGHT_W-1:0] FRIGHT_LOAD = FRIGHT_W'(FRIGHT_TICKS);
  localparam logic [FRIGHT_W-1:0] FLASH_LEVEL = FRIGHT_W'(FLASH_TICKS);

  ghost_modes_t         mode_q, mode_nx;
  logic [2:0]           phase_q, phase_nx;
  logic [SCHED_W-1:0]   sched_cnt, sched_cnt_nx;
  logic [FRIGHT_W-1:0]  fright_cnt, fright_cnt_nx;
  logic                 reverse_q, reverse_nx;

  logic         sched_run, advance, fright_expire, live;
  ghost_modes_t sched_mode, new_sched_mode;

  // Phase 7 never decrements, so its loaded length is irrelevant.
  function automatic logic [SCHED_W-1:0] phase_len(input logic [2:0] p);
    case (p)
      3'd0, 3'd2:       phase_len = LEN_SL;
      3'd1, 3'd3, 3'd5: phase_len = LEN_CH;
      3'd4, 3'd6:       phase_len = LEN_SS;
      default:          phase_len = '0;
    endcase
  endfunction

  // State register; restart behaves exactly like reset.
  always_ff @(posedge clk) begin
    if (rst || restart) begin
      mode_q     <= SCATTER;
      phase_q    <= '0;
      sched_cnt  <= LEN_SL;
      fright_cnt <= '0;
      reverse_q  <= 1'b0;
    end else begin
      mode_q     <= mode_nx;
      phase_q    <= phase_nx;
      sched_cnt  <= sched_cnt_nx;
      fright_cnt <= fright_cnt_nx;
      reverse_q  <= reverse_nx;
    end
  end

  // Counter updates run independently; mode follows a fixed event priority.
  always_comb begin
    sched_mode     = phase_q[0] ? CHASE : SCATTER;
    sched_run      = tick && (fright_cnt == '0) && (phase_q != 3'd7);
    advance        = sched_run && (sched_cnt == SCHED_W'(1));
    phase_nx       = advance ? phase_q + 3'd1 : phase_q;
    new_sched_mode = phase_nx[0] ? CHASE : SCATTER;
    if (advance)        sched_cnt_nx = phase_len(phase_nx);
    else if (sched_run) sched_cnt_nx = sched_cnt - SCHED_W'(1);
    else                sched_cnt_nx = sched_cnt;

    fright_expire = tick && (fright_cnt == FRIGHT_W'(1)) && !pellet_eaten;
    if (pellet_eaten)                    fright_cnt_nx = FRIGHT_LOAD;
    else if (tick && fright_cnt != '0)   fright_cnt_nx = fright_cnt - FRIGHT_W'(1);
    else                                 fright_cnt_nx = fright_cnt;

    live       = (mode_q == CHASE) || (mode_q == SCATTER);
    mode_nx    = mode_q;
    reverse_nx = 1'b0;
    if (ghost_home && mode_q == EATEN) begin
      mode_nx = sched_mode;
    end else if (ghost_eaten && mode_q == AFFRAID) begin
      mode_nx = EATEN;
    end else if (pellet_eaten) begin
      // A simultaneous phase advance folds into this single reverse pulse.
      if (live) begin
        mode_nx    = AFFRAID;
        reverse_nx = 1'b1;
      end
    end else if (fright_expire && mode_q == AFFRAID) begin
      mode_nx = sched_mode;
    end else if (advance && live) begin
      mode_nx    = new_sched_mode;
      reverse_nx = 1'b1;
    end
  end

  assign mode    = mode_q;
  assign phase   = phase_q;
  assign reverse = reverse_q;
  assign flash   = (mode_q == AFFRAID) && (fright_cnt <= FLASH_LEVEL);

endmodule

// File: tb/tb_ghost_mode_ctrl.sv
// Self-checking bench for ghost_mode_ctrl: directed scenarios plus random
// stimulus against a schedule-time based reference model.
module tb_ghost_mode_ctrl;

  localparam int SL = 4, SS = 3, CL = 6, FT = 5, FL = 2;
  localparam logic [1:0] CHASE = 2'd0, SCATTER = 2'd1, AFFRAID = 2'd2, EATEN = 2'd3;

  logic clk = 0, rst = 0, tick = 0, restart = 0;
  logic pellet_eaten = 0, ghost_eaten = 0, ghost_home = 0;
  logic [1:0] mode;
  logic reverse, flash;
  logic [2:0] phase;

  int errors = 0, checks = 0;

  ghost_mode_ctrl #(
    .SCATTER_LONG(SL), .SCATTER_SHORT(SS), .CHASE_LEN(CL),
    .FRIGHT_TICKS(FT), .FLASH_TICKS(FL)
  ) dut (
    .clk(clk), .rst(rst), .tick(tick), .restart(restart),
    .pellet_eaten(pellet_eaten), .ghost_eaten(ghost_eaten), .ghost_home(ghost_home),
    .mode(mode), .reverse(reverse), .flash(flash), .phase(phase)
  );

  always #5 clk = ~clk;

  // Schedule time (unfrozen ticks since reset) at which each phase 1..7 begins.
  int bnd[7];
  initial begin
    bnd[0] = SL;          bnd[1] = bnd[0] + CL; bnd[2] = bnd[1] + SL;
    bnd[3] = bnd[2] + CL; bnd[4] = bnd[3] + SS; bnd[5] = bnd[4] + CL;
    bnd[6] = bnd[5] + SS;
  end

  // Reference model: schedule expressed as elapsed game time, not counters.
  int         m_time, m_fright;
  logic [1:0] m_mode;
  logic       m_rev;

  function automatic int phase_of(input int t);
    int p = 0;
    for (int i = 0; i < 7; i++) if (t >= bnd[i]) p = i + 1;
    return p;
  endfunction

  function automatic logic [1:0] sched_of(input int p);
    return (p % 2 == 1) ? CHASE : SCATTER;
  endfunction

  function automatic void model_step(input bit t, pe, ge, gh, rs);
    int p0, p1, nt, nf;
    bit adv, expire, live;
    logic [1:0] nm;
    if (rs) begin
      m_time = 0; m_fright = 0; m_mode = SCATTER; m_rev = 0;
      return;
    end
    p0     = phase_of(m_time);
    nt     = (t && m_fright == 0 && p0 < 7) ? m_time + 1 : m_time;
    p1     = phase_of(nt);
    adv    = (p1 != p0);
    expire = t && m_fright == 1 && !pe;
    nf     = pe ? FT : ((t && m_fright > 0) ? m_fright - 1 : m_fright);
    live   = (m_mode == CHASE) || (m_mode == SCATTER);
    nm     = m_mode;
    m_rev  = 0;
    if (gh && m_mode == EATEN) nm = sched_of(p0);
    else if (ge && m_mode == AFFRAID) nm = EATEN;
    else if (pe) begin
      if (live) begin nm = AFFRAID; m_rev = 1; end
    end
    else if (expire && m_mode == AFFRAID) nm = sched_of(p0);
    else if (adv && live) begin nm = sched_of(p1); m_rev = 1; end
    m_time = nt; m_fright = nf; m_mode = nm;
  endfunction

  // Applies one cycle of inputs, advances the model, returns #1 after the edge.
  task automatic drive(input bit t, pe, ge, gh, rs);
    tick = t; pellet_eaten = pe; ghost_eaten = ge; ghost_home = gh; restart = rs;
    model_step(t, pe, ge, gh, rs);
    @(posedge clk); #1;
    tick = 0; pellet_eaten = 0; ghost_eaten = 0; ghost_home = 0; restart = 0;
  endtask

  task automatic do_reset();
    rst = 1;
    model_step(0, 0, 0, 0, 1);
    @(posedge clk); #1;
    rst = 0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) drive(1, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (mode !== SCATTER) begin errors++; $display("FAIL reset_mode got=%0d exp=%0d", mode, SCATTER); end
    checks++; if (phase !== 3'd0) begin errors++; $display("FAIL reset_phase got=%0d exp=0", phase); end
    checks++; if (reverse !== 1'b0) begin errors++; $display("FAIL reset_reverse got=%0b exp=0", reverse); end
    checks++; if (flash !== 1'b0) begin errors++; $display("FAIL reset_flash got=%0b exp=0", flash); end
  endtask

  task automatic test_schedule();
    int revs = 0, ep;
    do_reset();
    for (int k = 1; k <= 40; k++) begin
      drive(1, 0, 0, 0, 0);
      ep = phase_of(k);
      checks++; if (phase !== 3'(ep)) begin errors++; $display("FAIL sched_phase k=%0d got=%0d exp=%0d", k, phase, ep); end
      checks++; if (mode !== sched_of(ep)) begin errors++; $display("FAIL sched_mode k=%0d got=%0d exp=%0d", k, mode, sched_of(ep)); end
      checks++;
      if (reverse !== ((ep != phase_of(k - 1)) ? 1'b1 : 1'b0)) begin
        errors++; $display("FAIL sched_reverse k=%0d got=%0b", k, reverse);
      end
      if (reverse === 1'b1) revs++;
    end
    checks++; if (revs != 7) begin errors++; $display("FAIL sched_rev_count got=%0d exp=7", revs); end
  endtask

  task automatic test_fright();
    do_reset();
    ticks(SL + 3);
    drive(0, 1, 0, 0, 0);
    checks++; if (mode !== AFFRAID || reverse !== 1'b1) begin errors++; $display("FAIL fright_enter mode=%0d rev=%0b exp mode=2 rev=1", mode, reverse); end
    for (int i = 1; i <= FT - 1; i++) begin
      drive(1, 0, 0, 0, 0);
      checks++;
      if (flash !== ((FT - i <= FL) ? 1'b1 : 1'b0) || mode !== AFFRAID || reverse !== 1'b0) begin
        errors++; $display("FAIL fright_flash i=%0d flash=%0b mode=%0d rev=%0b", i, flash, mode, reverse);
      end
    end
    drive(1, 0, 0, 0, 0);
    checks++; if (mode !== CHASE || reverse !== 1'b0 || flash !== 1'b0) begin errors++; $display("FAIL fright_expire mode=%0d rev=%0b flash=%0b exp mode=0 rev=0 flash=0", mode, reverse, flash); end
    ticks(2);
    checks++; if (phase !== 3'd1 || mode !== CHASE) begin errors++; $display("FAIL fright_frozen phase=%0d mode=%0d exp phase=1 mode=0", phase, mode); end
    ticks(1);
    checks++; if (phase !== 3'd2 || mode !== SCATTER || reverse !== 1'b1) begin errors++; $display("FAIL fright_resume phase=%0d mode=%0d rev=%0b exp 2/1/1", phase, mode, reverse); end
  endtask

  task automatic test_eaten();
    do_reset();
    ticks(SL);
    drive(0, 1, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    drive(1, 0, 1, 0, 0);
    checks++; if (mode !== EATEN) begin errors++; $display("FAIL eaten_mode got=%0d exp=%0d", mode, EATEN); end
    drive(0, 0, 0, 1, 0);
    checks++; if (mode !== CHASE || flash !== 1'b0 || reverse !== 1'b0) begin errors++; $display("FAIL eaten_home mode=%0d flash=%0b rev=%0b exp 0/0/0", mode, flash, reverse); end
  endtask

  task automatic test_rearm();
    do_reset();
    drive(0, 1, 0, 0, 0);
    ticks(FT - 1);
    checks++; if (flash !== 1'b1) begin errors++; $display("FAIL rearm_flash_before got=%0b exp=1", flash); end
    drive(0, 1, 0, 0, 0);
    checks++; if (mode !== AFFRAID || reverse !== 1'b0 || flash !== 1'b0) begin errors++; $display("FAIL rearm_reload mode=%0d rev=%0b flash=%0b exp 2/0/0", mode, reverse, flash); end
    ticks(FT - FL - 1);
    checks++; if (flash !== 1'b0) begin errors++; $display("FAIL rearm_count got=%0b exp=0", flash); end
    drive(0, 1, 1, 0, 0);
    checks++; if (mode !== EATEN) begin errors++; $display("FAIL eat_and_pellet got=%0d exp=%0d", mode, EATEN); end
    drive(0, 1, 0, 0, 0);
    checks++; if (mode !== EATEN || reverse !== 1'b0) begin errors++; $display("FAIL pellet_while_eaten mode=%0d rev=%0b exp 3/0", mode, reverse); end
    drive(0, 0, 0, 1, 0);
    ticks(FT + SL - 1);
    checks++; if (phase !== 3'd0) begin errors++; $display("FAIL fright_reloaded_freeze phase=%0d exp=0", phase); end
    ticks(1);
    checks++; if (phase !== 3'd1) begin errors++; $display("FAIL fright_reloaded_release phase=%0d exp=1", phase); end
  endtask

  task automatic test_restart();
    do_reset();
    ticks(SL + CL + SL);
    drive(0, 1, 0, 0, 0);
    drive(0, 0, 1, 0, 0);
    checks++; if (mode !== EATEN || phase !== 3'd3) begin errors++; $display("FAIL restart_setup mode=%0d phase=%0d exp 3/3", mode, phase); end
    drive(0, 0, 0, 0, 1);
    checks++; if (mode !== SCATTER || phase !== 3'd0 || reverse !== 1'b0 || flash !== 1'b0) begin errors++; $display("FAIL restart_state mode=%0d phase=%0d rev=%0b flash=%0b", mode, phase, reverse, flash); end
    ticks(SL);
    checks++; if (phase !== 3'd1) begin errors++; $display("FAIL restart_fright_cleared phase=%0d exp=1", phase); end
  endtask

  task automatic test_random();
    bit t, pe, ge, gh, rs;
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      t  = ($urandom_range(0, 2) != 0);
      pe = ($urandom_range(0, 40) == 0);
      ge = ($urandom_range(0, 6) == 0);
      gh = ($urandom_range(0, 6) == 0);
      rs = ($urandom_range(0, 700) == 0);
      drive(t, pe, ge, gh, rs);
      checks++;
      if (mode !== m_mode || phase !== 3'(phase_of(m_time)) || reverse !== m_rev ||
          flash !== ((m_mode == AFFRAID && m_fright <= FL) ? 1'b1 : 1'b0)) begin
        errors++;
        $display("FAIL random i=%0d mode=%0d/%0d phase=%0d/%0d rev=%0b/%0b flash=%0b", i,
                 mode, m_mode, phase, phase_of(m_time), reverse, m_rev, flash);
      end
    end
  endtask

  initial begin
    test_reset();
    test_schedule();
    test_fright();
    test_eaten();
    test_rearm();
    test_restart();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
